// File: rtl/fa_word_collector.sv
// fa_word_collector: assembles LSB-first serial sum bits into a word
// and holds it with its final carry until the consumer takes it.
module fa_word_collector #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             s_valid,
   input  logic             s_sum,
   input  logic             s_cout,
   input  logic             m_ready,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_word,
   output logic             m_carry,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             carry_q, carry_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             ovr_q, ovr_d;

   logic             last_bit;
   logic [WIDTH-1:0] bit_mask;

   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   assign bit_mask = WIDTH'(1) << cnt_q;

   // Next-state, data path and registered status outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      carry_d = carry_q;
      ovr_d   = ovr_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               cnt_d   = '0;
               word_d  = '0;
               carry_d = 1'b0;
               ovr_d   = 1'b0;
            end
            // A stray bit is never stored; it only flags the error.
            if (s_valid) begin
               ovr_d = 1'b1;
            end
         end
         COLLECT: begin
            if (start) begin
               cnt_d   = '0;
               word_d  = '0;
               carry_d = 1'b0;
               if (s_valid) begin
                  word_d = WIDTH'(s_sum);
                  cnt_d  = CW'(1);
               end
            end else if (s_valid) begin
               word_d = (word_q & ~bit_mask)
                      | (s_sum ? bit_mask : '0);
               if (last_bit) begin
                  carry_d = s_cout;
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         HOLD: begin
            if (s_valid) begin
               ovr_d = 1'b1;
            end
            // start without m_ready is ignored so the word is kept.
            if (m_ready) begin
               word_d  = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = start ? COLLECT : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      valid_d = (state_d == HOLD);
      busy_d  = (state_d == COLLECT);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign m_valid = valid_q;
   assign m_word  = word_q;
   assign m_carry = carry_q;
   assign busy    = busy_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_fa_word_collector.sv
// tb_fa_word_collector: directed table, corner sequences and random
// stimulus checked against a queue-based model of the collector.
module tb_fa_word_collector;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, s_valid, s_sum, s_cout, m_ready;
   logic             m_valid, m_carry, busy, overrun;
   logic [WIDTH-1:0] m_word;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fa_word_collector #(.WIDTH(WIDTH)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .start   (start),
      .s_valid (s_valid),
      .s_sum   (s_sum),
      .s_cout  (s_cout),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_word  (m_word),
      .m_carry (m_carry),
      .busy    (busy),
      .overrun (overrun)
   );

   // Reference model: received bits kept in a queue.
   bit md_collect, md_hold, md_carry, md_ovr;
   bit md_bits[$];

   function automatic void md_reset();
      md_collect = 0;
      md_hold    = 0;
      md_carry   = 0;
      md_ovr     = 0;
      md_bits.delete();
   endfunction

   function automatic logic [WIDTH-1:0] md_word();
      logic [WIDTH-1:0] w;
      w = '0;
      foreach (md_bits[i]) w[i] = md_bits[i];
      return w;
   endfunction

   function automatic void md_step(bit st, bit sv, bit ss, bit sc,
                                   bit rdy);
      if (md_hold) begin
         if (sv) md_ovr = 1;
         if (rdy) begin
            md_hold  = 0;
            md_carry = 0;
            md_bits.delete();
            md_collect = st;
         end
      end else if (md_collect) begin
         if (st) md_bits.delete();
         if (sv) begin
            md_bits.push_back(ss);
            if (md_bits.size() == WIDTH) begin
               md_collect = 0;
               md_hold    = 1;
               md_carry   = sc;
            end
         end
      end else begin
         if (st) begin
            md_collect = 1;
            md_ovr     = 0;
            md_bits.delete();
         end
         if (sv) md_ovr = 1;
      end
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("m_valid", 32'(m_valid), 32'(md_hold));
      chk("m_word", 32'(m_word), 32'(md_word()));
      chk("m_carry", 32'(m_carry), 32'(md_carry));
      chk("busy", 32'(busy), 32'(md_collect));
      chk("overrun", 32'(overrun), 32'(md_ovr));
   endtask

   task automatic cyc(bit st, bit sv, bit ss, bit sc, bit rdy);
      start   = st;
      s_valid = sv;
      s_sum   = ss;
      s_cout  = sc;
      m_ready = rdy;
      @(posedge clk);
      md_step(st, sv, ss, sc, rdy);
      #1;
      chk_model();
   endtask

   task automatic send_word(logic [WIDTH-1:0] w, bit c);
      for (int i = 0; i < WIDTH; i++)
         cyc(0, 1, w[i], (i == WIDTH - 1) ? c : 1'b0, 0);
   endtask

   typedef struct {
      bit               st, sv, ss, sc, rdy;
      bit               ev;
      logic [WIDTH-1:0] ew;
      bit               ec, eb, eo;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // start, then bits 1,0,1,1,0,0,1,0 (carry on last), accept,
      // stray bit in IDLE, new start
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0};
      tbl[1]  = '{0, 1, 1, 0, 0, 0, 8'h01, 0, 1, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 8'h01, 0, 1, 0};
      tbl[3]  = '{0, 1, 1, 0, 0, 0, 8'h05, 0, 1, 0};
      tbl[4]  = '{0, 1, 1, 0, 0, 0, 8'h0D, 0, 1, 0};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 8'h0D, 0, 1, 0};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 8'h0D, 0, 1, 0};
      tbl[7]  = '{0, 1, 1, 0, 0, 0, 8'h4D, 0, 1, 0};
      tbl[8]  = '{0, 1, 0, 1, 0, 1, 8'h4D, 1, 0, 0};
      tbl[9]  = '{0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0};
      tbl[10] = '{0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 1};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0};

      rst_n   = 0;
      start   = 0;
      s_valid = 0;
      s_sum   = 0;
      s_cout  = 0;
      m_ready = 0;
      md_reset();
      #2;
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_word", 32'(m_word), 32'd0);
      chk("rst_carry", 32'(m_carry), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      #10;
      rst_n = 1;

      for (int r = 0; r < 12; r++) begin
         cyc(tbl[r].st, tbl[r].sv, tbl[r].ss, tbl[r].sc, tbl[r].rdy);
         chk("tbl_valid", 32'(m_valid), 32'(tbl[r].ev));
         chk("tbl_word", 32'(m_word), 32'(tbl[r].ew));
         chk("tbl_carry", 32'(m_carry), 32'(tbl[r].ec));
         chk("tbl_busy", 32'(busy), 32'(tbl[r].eb));
         chk("tbl_ovr", 32'(overrun), 32'(tbl[r].eo));
      end

      // Same stream with random gaps; restart from COLLECT.
      begin
         logic [WIDTH-1:0] pat;
         pat = 8'h4D;
         cyc(1, 0, 0, 0, 0);
         for (int i = 0; i < WIDTH; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
               cyc(0, 0, 1, 1, 0);
               chk("gap_busy", 32'(busy), 32'd1);
            end
            cyc(0, 1, pat[i], (i == WIDTH - 1) ? 1'b1 : 1'b0, 0);
         end
         chk("gap_word", 32'(m_word), 32'h4D);
         chk("gap_carry", 32'(m_carry), 32'd1);
         chk("gap_valid", 32'(m_valid), 32'd1);
      end

      // Stall in HOLD while pulsing start; then back-to-back.
      for (int k = 0; k < 5; k++) begin
         cyc((k % 2) == 0, 0, 0, 0, 0);
         chk("hold_word", 32'(m_word), 32'h4D);
         chk("hold_valid", 32'(m_valid), 32'd1);
      end
      cyc(1, 0, 0, 0, 1);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_valid", 32'(m_valid), 32'd0);

      // Restart after 4 bits, then all ones.
      for (int i = 0; i < 4; i++) cyc(0, 1, 1'($urandom), 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rs_word0", 32'(m_word), 32'd0);
      send_word(8'hFF, 0);
      chk("rs_word", 32'(m_word), 32'hFF);
      chk("rs_valid", 32'(m_valid), 32'd1);
      cyc(0, 0, 0, 0, 1);

      // Overrun: set in IDLE, clear on start, set in HOLD, sticky.
      cyc(0, 1, 1, 1, 0);
      chk("ovr_idle", 32'(overrun), 32'd1);
      chk("ovr_word", 32'(m_word), 32'd0);
      cyc(1, 0, 0, 0, 0);
      chk("ovr_clr", 32'(overrun), 32'd0);
      send_word(8'h3C, 1);
      cyc(0, 1, 1, 0, 0);
      chk("ovr_hold", 32'(overrun), 32'd1);
      chk("ovr_hword", 32'(m_word), 32'h3C);
      cyc(1, 0, 0, 0, 1);
      send_word(8'h81, 0);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      cyc(0, 0, 0, 0, 1);
      chk("ovr_idle2", 32'(overrun), 32'd1);
      cyc(1, 0, 0, 0, 0);
      chk("ovr_clr2", 32'(overrun), 32'd0);

      // Asynchronous reset after 6 bits.
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
      #3;
      rst_n   = 0;
      start   = 0;
      s_valid = 0;
      m_ready = 0;
      md_reset();
      #1;
      chk("arst_valid", 32'(m_valid), 32'd0);
      chk("arst_word", 32'(m_word), 32'd0);
      chk("arst_carry", 32'(m_carry), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ovr", 32'(overrun), 32'd0);
      #2;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("arst_novalid", 32'(m_valid), 32'd0);
      end
      cyc(1, 0, 0, 0, 0);
      send_word(8'hA5, 1);
      chk("post_word", 32'(m_word), 32'hA5);
      chk("post_carry", 32'(m_carry), 32'd1);
      cyc(0, 0, 0, 0, 1);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 9) == 0,
             $urandom_range(0, 2) != 0,
             1'($urandom), 1'($urandom),
             1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
